// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: FSM state encoding and counter sizing helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one so a single-digit
    // configuration still has a legal counter register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple slice built from full_adder cells; also exposes the carry
// into its MSB so the caller can derive signed overflow on the last digit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             CI,
    output logic [DIGIT-1:0] S,
    output logic             CO,
    output logic             C_MSB
);

    logic [DIGIT:0] carry;

    assign carry[0] = CI;

    for (genvar i = 0; i < DIGIT; i++) begin : gBit
        full_adder uFa (
            .A    (A[i]),
            .B    (B[i]),
            .CIN  (carry[i]),
            .S    (S[i]),
            .COUT (carry[i+1])
        );
    end

    assign CO    = carry[DIGIT];
    assign C_MSB = carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the digit slice.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB digit
// first, with a START/READY/DONE handshake. Results are published only when
// an operation completes, so SUM/COUT/OVF never show partial values.
module digit_serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG);

    if (DIGIT < 1) begin : gBadDigit
        $error("digit_serial_addsub: DIGIT must be at least 1");
    end else if ((WIDTH % DIGIT) != 0) begin : gBadRatio
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [DIGIT-1:0] sliceSum;
    logic             sliceCo;
    logic             sliceCMsb;
    logic             lastDigit;

    digit_adder #(
        .DIGIT (DIGIT)
    ) uSlice (
        .A     (a_q[DIGIT-1:0]),
        .B     (b_q[DIGIT-1:0]),
        .CI    (carry_q),
        .S     (sliceSum),
        .CO    (sliceCo),
        .C_MSB (sliceCMsb)
    );

    // The A register doubles as the result register: each slice result enters
    // at the top as the consumed operand digit leaves at the bottom, so after
    // NDIG shifts it holds the assembled result.
    if (DIGIT == WIDTH) begin : gOneDigit
        assign a_d = sliceSum;
        assign b_d = '0;
    end else begin : gMultiDigit
        assign a_d = {sliceSum, a_q[WIDTH-1:DIGIT]};
        assign b_d = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end

    assign lastDigit = (cnt_q == CW'(NDIG - 1));

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE_S: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{SUB}};
                        carry_q <= CIN ^ SUB;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    carry_q <= sliceCo;
                    cnt_q   <= cnt_q + 1'b1;
                    if (lastDigit) begin
                        state_q <= DONE_S;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        sum_q   <= a_d;
                        cout_q  <= sliceCo;
                        ovf_q   <= sliceCMsb ^ sliceCo;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign READY = ready_q;
    assign DONE  = done_q;
    assign SUM   = sum_q;
    assign COUT  = cout_q;
    assign OVF   = ovf_q;

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor: the generational successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple slice.
- Carry/borrow is held in a register between digits.
- Sits in the ALU datapath as the area-reduced arithmetic unit, with a START/READY/DONE handshake towards the ALU controller.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT == 0 and DIGIT >= 1 are required (elaboration error otherwise).
- NDIG (localparam), WIDTH/DIGIT, number of digit cycles.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  operation request, sampled only when READY=1.
- SUB  input  1  0 = add, 1 = subtract. Latched on acceptance.
- CIN  input  1  carry-in (add) / borrow-in (sub). Latched on acceptance.
- A  input  WIDTH  operand A, latched on acceptance.
- B  input  WIDTH  operand B, latched on acceptance.
- READY  output  1  high when a START will be accepted.
- DONE  output  1  one-cycle pulse: result valid and updated.
- SUM  output  WIDTH  result.
- COUT  output  1  final carry out (sub: 1 = no borrow).
- OVF  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE; READY=1; DONE=0; SUM=0; COUT=0; OVF=0.
  - All internal shift registers and the carry register are cleared.
  - Reset asserted mid-operation aborts it; no DONE is produced.
- States and transitions:
  - IDLE -> RUN on START=1.
  - RUN -> RUN while digit count < NDIG-1.
  - RUN -> DONE_S on the edge that processes the last digit.
  - DONE_S -> RUN if START=1, else IDLE.
- READY=1 in IDLE and DONE_S, 0 in RUN.
- Acceptance: on the rising edge with READY=1 and START=1:
  - Capture A, B^{WIDTH{SUB}}, and the initial carry c0 = CIN ^ SUB.
  - Digit counter <= 0.
- Arithmetic:
  - Subtract computes A - B - CIN as A + ~B + ~CIN.
  - Each RUN cycle adds the low DIGIT bits of the A/B shift registers plus the carry register.
  - The DIGIT result bits are shifted into the result shift register from the MSB end.
  - Operand registers shift right by DIGIT; the carry register takes the slice carry-out.
- Last digit: the carry into bit WIDTH-1 (c_msb) and the carry out (c_out) are taken from the slice.
- Result registers are updated only on the transition into DONE_S:
  - SUM <= assembled result.
  - COUT <= c_out.
  - OVF <= c_msb ^ c_out.
  - SUM, COUT and OVF hold their values until the next DONE; they never show partial results.
- Latency:
  - With START accepted at edge e0, DONE=1 in the cycle after edge e0+NDIG, for exactly one cycle.
  - Throughput is one op per NDIG+1 cycles back-to-back (START asserted during DONE_S).
  - DIGIT=WIDTH gives NDIG=1, i.e. DONE two cycles after the START cycle.
- Boundary conditions:
  - START while READY=0 is ignored, not queued.
  - A, B, SUB and CIN changing during RUN have no effect.
  - The slice carry chain has no wrap-around; the carry register only carries between digits of the same op.
  - START and reset deassertion in the same cycle: START is sampled only on edges where RST_N=1.

Decomposition:
- Shared package/header alu_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE_S=2'd2;
  - digit-counter width function clog2(NDIG).
- Sub-module digit_adder:
  - parameter DIGIT;
  - DIGIT-bit ripple of the existing full_adder cells;
  - outputs S[DIGIT], CO, and C_MSB (carry into the slice MSB).
- Top: FSM, counter, shift registers, carry register and output registers.

Test Plan:
- WIDTH=16, DIGIT=4, SUB=0, CIN=0, A=0x1234, B=0x0FFF -> DONE pulses 5 cycles after the START cycle; SUM=0x2233, COUT=0, OVF=0.
- SUB=0, A=0x7FFF, B=0x0001, CIN=0 -> SUM=0x8000, COUT=0, OVF=1. Then A=0xFFFF, B=0x0001, CIN=1 -> SUM=0x0001, COUT=1, OVF=0.
- SUB=1, A=0x0005, B=0x0007, CIN=0 -> SUM=0xFFFE, COUT=0, OVF=0. Then A=0x8000, B=0x0001 -> SUM=0x7FFF, COUT=1, OVF=1.
- START held high continuously with new operands each DONE cycle -> accepted in every DONE_S cycle. START pulses during RUN are ignored, and the next result matches the operands latched at acceptance.
- RST_N pulsed low in the 2nd RUN cycle -> outputs 0, READY=1 immediately, no DONE. A new op after reset gives the correct result.
- Re-elaborate with DIGIT=16 and DIGIT=1 -> random-operand comparison against A±B±CIN with the golden model passes. DIGIT=1 latency is 17 cycles.
